seg_scan_driver: RTL
====================

# seg_scan_driver

Parametrised, time-multiplexed driver for a common-anode N-digit seven-segment display. It latches a packed BCD/hex word, decimal points and leading-zero control, then scans one digit at a time with a programmable refresh rate and an anti-ghosting blank guard. It sits between datapath/status logic and the board display pins, and replaces per-digit combinational decoders.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned (1–8).
- `REFRESH_DIV`, 50000: clocks per digit slot (≥ `GHOST_GUARD`+2).
- `GHOST_GUARD`, 2: clocks at the start of each slot with all anodes off.
- `HEX_MODE`, 1: 1 shows A–F glyphs for codes 10–15; 0 shows all segments lit for codes 10–15.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `value`  in  4*NUM_DIGITS  packed digit codes; digit 0 = bits [3:0] (rightmost).
- `dp_in`  in  NUM_DIGITS  decimal-point request per digit, 1 = lit.
- `lz_blank`  in  1  leading-zero suppression request.
- `load`  in  1  capture `value`, `dp_in`, `lz_blank` into shadow registers.
- `enable`  in  1  1 = scan and display; 0 = dark and frozen.
- `seg`  out  7  {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.
- `an`  out  NUM_DIGITS  digit anodes, active-low, at most one low.
- `slot_tick`  out  1  one-cycle pulse on each digit-slot boundary.

## Operation
- Reset (`rst_n`=0 at a clock edge): prescaler=0, idx=0, shadow value/dp/lz=0; `seg`=7'b1111111, `dp`=1, `an`=all 1s, `slot_tick`=0.
- Shadow capture: on a clock edge with `load`=1, all three shadow registers update together. Without `load`, the shadows hold. No partial updates.
- Prescaler counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0, and idx advances with wrap from NUM_DIGITS-1 to 0.
- Guard: while prescaler < GHOST_GUARD, all anodes are off and `seg`/`dp` are blank. Otherwise `an[idx]`=0.
- Decode, per shadow nibble: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000.
  - HEX_MODE=1: A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110.
  - HEX_MODE=0: codes 10–15 → 0000000.
- Leading-zero suppression (shadow lz=1):
  - Digit k is blanked (anode still driven, `seg` all 1s) when k>0, its nibble is 0, and all higher nibbles are 0.
  - Digit 0 is never blanked.
  - A blanked digit still shows its dp if requested.
- `enable`=0: prescaler and idx hold, outputs go dark (`an` all 1s, `seg`/`dp` 1s), `slot_tick`=0. Shadow capture still works. Scan resumes from the held state when `enable` returns to 1.

## Timing
- `seg`, `dp`, `an`, `slot_tick` are all registered.
- Outputs reflect prescaler/idx/shadow state with 1-cycle latency.
- `slot_tick`=1 in the cycle after the prescaler wraps. This coincides with the first guard cycle of the new slot.
- A `load` at edge t affects outputs from edge t+1 for the digit currently displayed.
- `load` and a slot wrap on the same edge: both take effect; the new slot shows the new data.
- `rst_n` low mid-slot: all outputs return to reset values at that edge. The scan restarts at digit 0 with a full guard interval.
- Full scan period = NUM_DIGITS*REFRESH_DIV clocks.

## Structure
- Package `seg_pkg`: the 16 glyph constants, `SEG_BLANK`=7'b1111111, and the function or typedef for a 7-bit segment vector.
- Sub-module `seg_decode`: combinational nibble→segment decoder with a `HEX_MODE` parameter, instantiated once on the selected nibble.
- Top level holds the prescaler, idx, shadows, LZ mask generation and output registers.

## Test plan
Bench configuration: NUM_DIGITS=4, REFRESH_DIV=8, GHOST_GUARD=2.
- Reset, then `enable`=1, `load` with value=16'h1234:
  - cycles 1–2: `an`=4'b1111;
  - cycles 3–8: `an`=4'b1110, `seg`=0011001;
  - next slot: digit 1 shows 0110000.
- Load 16'h00A0 with lz=1, HEX_MODE=1:
  - digits 3 and 2 blank with anode low;
  - digit 1 = 0001000;
  - digit 0 = 1000000.
- Load 16'h0000 with lz=1 and dp_in=4'b0100: digit 0 shows 1000000; digit 2 is blank with `dp`=0.
- HEX_MODE=0 build, value=16'hFFFF: every digit shows 0000000.
- Mid-slot `enable`=0 for 5 cycles, then 1: outputs dark for 5 cycles; the slot resumes and completes its remaining count; `slot_tick` spacing is 8+5 clocks.
- `load` on the same edge as a prescaler wrap, then `rst_n`=0 mid-slot: the new digit shows the new data; on the reset edge outputs return to 1111111 / 1 / 4'b1111 and the scan restarts at digit 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Segment glyph constants shared by the scan driver and its decoder.
// Latency: none (constants only).
// Backpressure: none.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low (0 = lit).
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b0000011;
    localparam seg_t SEG_C     = 7'b1000110;
    localparam seg_t SEG_D     = 7'b0100001;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_F     = 7'b0001110;
    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_ALL   = 7'b0000000;

endpackage

// File: rtl/seg_decode.sv
// Nibble to seven-segment decoder (active-low {g,f,e,d,c,b,a}).
// Latency: combinational.
// Backpressure: none.
// Ports: i_nib - 4-bit digit code; o_seg - segment pattern.
// HEX_MODE=1 draws A-F glyphs for codes 10-15; HEX_MODE=0 lights every segment instead.
module seg_decode
    import seg_pkg::*;
#(
    parameter int HEX_MODE = 1
) (
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nib)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = (HEX_MODE != 0) ? SEG_A : SEG_ALL;
            4'hB: o_seg = (HEX_MODE != 0) ? SEG_B : SEG_ALL;
            4'hC: o_seg = (HEX_MODE != 0) ? SEG_C : SEG_ALL;
            4'hD: o_seg = (HEX_MODE != 0) ? SEG_D : SEG_ALL;
            4'hE: o_seg = (HEX_MODE != 0) ? SEG_E : SEG_ALL;
            4'hF: o_seg = (HEX_MODE != 0) ? SEG_F : SEG_ALL;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode N-digit seven-segment scan driver with blank guard.
// Latency: all outputs registered, 1 cycle behind prescaler/digit/shadow state.
// Backpressure: none; i_enable=0 freezes the scan and darkens the display.
// Ports: i_clk, i_rst_n (sync, active-low), i_value (packed nibbles, digit 0 = [3:0]),
//        i_dp_in, i_lz_blank, i_load (shadow capture), i_enable;
//        o_seg/o_dp/o_an (active-low pins), o_slot_tick (slot boundary pulse).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GHOST_GUARD = 2,
    parameter int HEX_MODE    = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp_in,
    input  logic                    i_lz_blank,
    input  logic                    i_load,
    input  logic                    i_enable,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_slot_tick
);

    localparam int PW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0]         PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]         GUARD     = PW'(GHOST_GUARD);
    localparam logic [IDX_W-1:0]      IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);

    logic [PW-1:0]           r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic                    r_lz;
    logic                    r_wrap_pend;

    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic [3:0]              w_nib;
    logic                    w_cur_dp;
    logic                    w_cur_blank;
    logic [6:0]              w_dec;
    logic                    w_wrap;

    assign w_wrap = (r_presc == PRESC_MAX);

    // Walk from the most significant digit down: a digit is suppressed only
    // while every nibble from the top down to it is zero. Digit 0 never is.
    always_comb begin
        logic w_zero_run;
        w_lz_mask  = '0;
        w_zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero_run   = w_zero_run & (r_value[4*k +: 4] == 4'h0);
            w_lz_mask[k] = r_lz & w_zero_run;
        end
    end

    always_comb begin
        w_nib       = 4'h0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib       = r_value[4*k +: 4];
                w_cur_dp    = r_dp[k];
                w_cur_blank = w_lz_mask[k];
            end
        end
    end

    seg_decode #(
        .HEX_MODE (HEX_MODE)
    ) u_seg_decode (
        .i_nib (w_nib),
        .o_seg (w_dec)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_presc     <= '0;
            r_idx       <= '0;
            r_value     <= '0;
            r_dp        <= '0;
            r_lz        <= 1'b0;
            r_wrap_pend <= 1'b0;
            o_seg       <= SEG_BLANK;
            o_dp        <= 1'b1;
            o_an        <= '1;
            o_slot_tick <= 1'b0;
        end else begin
            if (i_load) begin
                r_value <= i_value;
                r_dp    <= i_dp_in;
                r_lz    <= i_lz_blank;
            end

            if (i_enable) begin
                if (w_wrap) begin
                    r_presc <= '0;
                    r_idx   <= (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
                end else begin
                    r_presc <= r_presc + PW'(1);
                end

                // The wrap is remembered until the next enabled edge so the
                // tick lands on the pins together with the first guard cycle,
                // even if the scan is paused right after the wrap.
                r_wrap_pend <= w_wrap;
                o_slot_tick <= r_wrap_pend;

                if (r_presc < GUARD) begin
                    o_an  <= '1;
                    o_seg <= SEG_BLANK;
                    o_dp  <= 1'b1;
                end else begin
                    o_an  <= ~(AN_ONE << r_idx);
                    o_seg <= w_cur_blank ? SEG_BLANK : w_dec;
                    o_dp  <= ~w_cur_dp;
                end
            end else begin
                o_an        <= '1;
                o_seg       <= SEG_BLANK;
                o_dp        <= 1'b1;
                o_slot_tick <= 1'b0;
            end
        end
    end

endmodule
